// File: rtl/fifo_p_sync.sv
// Single-clock packet FIFO with sop/eop framing.
// Admits a packet only when MAX_PKT words are free at its sop and drops the rest whole.
// A packet that still fills the RAM is truncated: the last writable word is stored
// with eop forced and the remainder is dropped.
// Optional build macro STORE_FWD_EN: output waits for a complete stored packet.
// Without it the FIFO is cut-through and output starts as soon as any word is stored.
module fifo_p_sync #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned MAX_PKT = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              b_rdy,
    input  logic              din_vld,
    input  logic              din_sop,
    input  logic [DATA_W-1:0] din,
    input  logic              din_eop,
    output logic              dout_vld,
    output logic              dout_sop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_eop
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned PW    = ADDR_W + 1;

    typedef logic [PW-1:0] ptr_t;

    localparam ptr_t DepthP  = ptr_t'(DEPTH);
    localparam ptr_t MaxPktP = ptr_t'(MAX_PKT);

    typedef enum logic [1:0] {StIdle, StAccept, StDrop} wr_state_e;

    // Each entry is {sop, eop, data}
    logic [DATA_W+1:0] mem [DEPTH];

    wr_state_e         state_q, state_d;
    ptr_t              wr_ptr_q, rd_ptr_q, pkt_cnt_q;
    logic [15:0]       drop_cnt_q;

    ptr_t              used, free;
    logic              admit, last_slot;
    logic              wr_en, wr_sop, wr_eop, dropped;
    logic              avail, rd_en;
    logic [DATA_W+1:0] rd_word;
    logic              rd_eop;

    assign used      = wr_ptr_q - rd_ptr_q;
    assign free      = DepthP - used;
    assign admit     = (free >= MaxPktP);
    // Only one slot left: this write fills the RAM
    assign last_slot = (free == ptr_t'(1));

`ifdef STORE_FWD_EN
    assign avail = (pkt_cnt_q != '0);
`else
    assign avail = (used != '0);
`endif

    assign rd_en   = b_rdy & avail;
    assign rd_word = mem[rd_ptr_q[ADDR_W-1:0]];
    assign rd_eop  = rd_word[DATA_W];

    // Write FSM next state and write-side controls
    always_comb begin
        state_d = state_q;
        wr_en   = 1'b0;
        wr_sop  = 1'b0;
        wr_eop  = 1'b0;
        dropped = 1'b0;
        if (din_vld) begin
            unique case (state_q)
                StIdle: begin
                    if (din_sop) begin
                        if (admit) begin
                            wr_en  = 1'b1;
                            wr_sop = 1'b1;
                            wr_eop = din_eop;
                            if (!din_eop) begin
                                state_d = StAccept;
                            end
                        end else if (din_eop) begin
                            // Refused single-word packet: nothing follows to discard
                            dropped = 1'b1;
                        end else begin
                            state_d = StDrop;
                        end
                    end
                end
                StAccept: begin
                    // A repeated sop is stored with its sop flag cleared
                    wr_en  = 1'b1;
                    wr_eop = din_eop;
                    if (din_eop) begin
                        state_d = StIdle;
                    end else if (last_slot) begin
                        wr_eop  = 1'b1;
                        state_d = StDrop;
                    end
                end
                StDrop: begin
                    if (din_eop) begin
                        dropped = 1'b1;
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    // Storage write port; contents need no reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q[ADDR_W-1:0]] <= {wr_sop, wr_eop, din};
        end
    end

    // Pointers, counters, FSM state and registered read outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
            dout_vld   <= 1'b0;
            dout_sop   <= 1'b0;
            dout_eop   <= 1'b0;
            dout       <= '0;
        end else begin
            state_q <= state_d;
            if (wr_en) begin
                wr_ptr_q <= wr_ptr_q + ptr_t'(1);
            end
            if (rd_en) begin
                rd_ptr_q <= rd_ptr_q + ptr_t'(1);
            end
            if ((wr_en && wr_eop) && !(rd_en && rd_eop)) begin
                pkt_cnt_q <= pkt_cnt_q + ptr_t'(1);
            end else if (!(wr_en && wr_eop) && (rd_en && rd_eop)) begin
                pkt_cnt_q <= pkt_cnt_q - ptr_t'(1);
            end
            if (dropped && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
            if (rd_en) begin
                dout_vld <= 1'b1;
                dout_sop <= rd_word[DATA_W+1];
                dout_eop <= rd_eop;
                dout     <= rd_word[DATA_W-1:0];
            end else begin
                // dout holds its last value between beats
                dout_vld <= 1'b0;
                dout_sop <= 1'b0;
                dout_eop <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_p_sync.sv
// Testbench for fifo_p_sync: a framing vector table plus packet-level sequences
// for reset, streaming, backpressure/admission, truncation and mid-packet pause.
module tb_fifo_p_sync;

    logic       clk = 1'b0;
    logic       rst;
    logic       b_rdy;
    logic       din_vld;
    logic       din_sop;
    logic [7:0] din;
    logic       din_eop;
    logic       dout_vld;
    logic       dout_sop;
    logic [7:0] dout;
    logic       dout_eop;

    fifo_p_sync dut (
        .clk      (clk),
        .rst      (rst),
        .b_rdy    (b_rdy),
        .din_vld  (din_vld),
        .din_sop  (din_sop),
        .din      (din),
        .din_eop  (din_eop),
        .dout_vld (dout_vld),
        .dout_sop (dout_sop),
        .dout     (dout),
        .dout_eop (dout_eop)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       vld;
        bit       sop;
        bit       eop;
        bit [7:0] data;
        bit       kept;
        bit       exp_sop;
        bit       exp_eop;
    } vec_t;

    vec_t       tbl [12];
    logic [9:0] got   [$];
    logic [9:0] exp_q [$];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         sop_cyc, eop_cyc, first_cyc;
    bit         first_seen;
    int         low_run, max_low;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (dout_vld) begin
            got.push_back({dout_sop, dout_eop, dout});
            if (!first_seen) begin
                first_seen = 1'b1;
                first_cyc  = cyc;
            end
        end
        if (b_rdy) begin
            low_run = 0;
        end else if (dout_vld) begin
            low_run++;
            if (low_run > max_low) max_low = low_run;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            if (n_err <= 30) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            din_vld = 1'b0;
            din_sop = 1'b0;
            din_eop = 1'b0;
        end
    endtask

    // keep_n: words expected to survive (len = whole, 0 = dropped, else truncated)
    task automatic send_pkt(input int len, input int base, input int keep_n);
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            #1;
            din_vld = 1'b1;
            din_sop = (i == 0);
            din_eop = (i == len - 1);
            din     = 8'(base + i);
            if (i == 0) sop_cyc = cyc;
            if (i == len - 1) eop_cyc = cyc;
            if (i < keep_n) begin
                exp_q.push_back({(i == 0), (i == keep_n - 1), 8'(base + i)});
            end
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst     = 1'b1;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        got.delete();
        exp_q.delete();
    endtask

    task automatic drain();
        int t = 0;
        while (got.size() < exp_q.size() && t < 4000) begin
            @(posedge clk);
            t++;
        end
        repeat (8) @(posedge clk);
    endtask

    task automatic compare_stream(input string tag);
        int n;
        check({tag, "_len"}, got.size(), exp_q.size());
        n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_word%0d", tag, i), int'(got[i]), int'(exp_q[i]));
        end
        got.delete();
        exp_q.delete();
    endtask

    function automatic vec_t mk(bit vld, bit sop, bit eop, bit [7:0] data, bit kept,
                                bit exp_sop, bit exp_eop);
        vec_t v;
        v.vld     = vld;
        v.sop     = sop;
        v.eop     = eop;
        v.data    = data;
        v.kept    = kept;
        v.exp_sop = exp_sop;
        v.exp_eop = exp_eop;
        return v;
    endfunction

    initial begin
        int nsop, neop;

        // Framing vectors: discarded orphans, mid-packet sop, single-word packet
        tbl[0]  = mk(1, 0, 0, 8'hA1, 0, 0, 0);
        tbl[1]  = mk(1, 0, 1, 8'hA2, 0, 0, 0);
        tbl[2]  = mk(1, 1, 0, 8'h10, 1, 1, 0);
        tbl[3]  = mk(1, 0, 0, 8'h11, 1, 0, 0);
        tbl[4]  = mk(1, 1, 0, 8'h12, 1, 0, 0);
        tbl[5]  = mk(0, 0, 0, 8'hEE, 0, 0, 0);
        tbl[6]  = mk(1, 0, 1, 8'h13, 1, 0, 1);
        tbl[7]  = mk(1, 1, 1, 8'h55, 1, 1, 1);
        tbl[8]  = mk(1, 0, 0, 8'h77, 0, 0, 0);
        tbl[9]  = mk(1, 1, 0, 8'h20, 1, 1, 0);
        tbl[10] = mk(1, 0, 1, 8'h21, 1, 0, 1);
        tbl[11] = mk(1, 0, 1, 8'h99, 0, 0, 0);

        first_seen = 1'b1;
        low_run    = 0;
        max_low    = 0;

        // 1. Reset held with traffic present
        rst     = 1'b1;
        b_rdy   = 1'b1;
        din_vld = 1'b1;
        din_sop = 1'b1;
        din_eop = 1'b1;
        din     = 8'h5A;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_vld", dout_vld, 0);
            check("rst_sop", dout_sop, 0);
            check("rst_eop", dout_eop, 0);
            check("rst_dout", dout, 0);
        end
        @(posedge clk);
        #1;
        rst     = 1'b0;
        din_vld = 1'b0;
        din_sop = 1'b0;
        din_eop = 1'b0;
        got.delete();
        idle(10);
        check("rst_nothing_stored", got.size(), 0);

        // 2. Single 191-word packet, first-beat latency
        first_seen = 1'b0;
        send_pkt(191, 0, 191);
        idle(1);
        drain();
`ifdef STORE_FWD_EN
        check("sf_latency", first_cyc - eop_cyc, 2);
`else
        check("ct_latency", first_cyc - sop_cyc, 2);
`endif
        compare_stream("single");

        // 3. Burst of 15 packets with 5 idle cycles between
        for (int p = 0; p < 15; p++) begin
            send_pkt(191, p * 13, 191);
            idle(5);
        end
        drain();
        nsop = 0;
        neop = 0;
        foreach (got[i]) begin
            nsop += int'(got[i][9]);
            neop += int'(got[i][8]);
        end
        check("burst_sops", nsop, 15);
        check("burst_eops", neop, 15);
        compare_stream("burst");

        // 5. Framing table
        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            din_vld = tbl[i].vld;
            din_sop = tbl[i].sop;
            din_eop = tbl[i].eop;
            din     = tbl[i].data;
            if (tbl[i].kept) exp_q.push_back({tbl[i].exp_sop, tbl[i].exp_eop, tbl[i].data});
        end
        idle(1);
        drain();
        compare_stream("framing");
        check("drops_after_framing", int'(dut.drop_cnt_q), 0);

        // 4. Backpressure: five packets fit (260 free at the fifth), sixth refused (69 free)
        do_reset();
        b_rdy = 1'b0;
        for (int p = 0; p < 6; p++) begin
            send_pkt(191, p * 7, (p < 5) ? 191 : 0);
            idle(5);
        end
        check("bp_no_output", got.size(), 0);
        check("bp_drops", int'(dut.drop_cnt_q), 1);
        @(posedge clk);
        #1;
        b_rdy = 1'b1;
        drain();
        compare_stream("backpressure");

        // Truncation: 573 stored leaves 451 free, long packet cut at its 451st word
        do_reset();
        b_rdy = 1'b0;
        for (int p = 0; p < 3; p++) begin
            send_pkt(191, p * 3, 191);
            idle(2);
        end
        send_pkt(600, 100, 451);
        idle(2);
        send_pkt(10, 200, 0);
        idle(2);
        check("trunc_drops", int'(dut.drop_cnt_q), 2);
        @(posedge clk);
        #1;
        b_rdy = 1'b1;
        drain();
        compare_stream("truncate");

        // 6. Mid-packet pause: b_rdy toggles every 3 cycles
        do_reset();
        max_low = 0;
        low_run = 0;
        fork
            begin
                send_pkt(191, 50, 191);
                idle(1);
            end
            begin
                repeat (150) begin
                    repeat (3) @(posedge clk);
                    #1;
                    b_rdy = ~b_rdy;
                end
            end
        join
        @(posedge clk);
        #1;
        b_rdy = 1'b1;
        drain();
        check("pause_beats_after_fall", int'(max_low <= 1), 1);
        compare_stream("pause");
        check("pause_drops", int'(dut.drop_cnt_q), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
